// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memory widths and word/index typedefs
package mem_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] widx_t;

endpackage

// File: rtl/data_memory.sv
// rtl/data_memory.sv - word-organised data RAM, sync write, async read, async clear
module data_memory #(
   parameter int DATA_W = mem_pkg::DATA_W,
   parameter int ADDR_W = mem_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [31:0]       a,
   input  logic [DATA_W-1:0] wd,
   output logic [DATA_W-1:0] rd
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] idx;

   // Byte offset and bits above the 4 KiB window are dropped, so unaligned
   // addresses land on their containing word and high addresses alias.
   function automatic logic [ADDR_W-1:0] word_index(input logic [31:0] addr);
      logic unused_bits;
      unused_bits = ^{addr[31:ADDR_W+2], addr[1:0]};
      return addr[ADDR_W+1:2];
   endfunction

   assign idx = word_index(a);

   // Full-word store on the clock edge; reset wipes every word and blocks writes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we == 1'b1) begin
         mem[idx] <= wd;
      end
   end

   // Zero-latency load; forced to zero while reset is held
   always_comb begin
      rd = reset ? '0 : mem[idx];
   end

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - scoreboard bench for data_memory against an array model
module tb_data_memory;

   logic        clk;
   logic        reset;
   logic        we;
   logic [31:0] a;
   logic [31:0] wd;
   logic [31:0] rd;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [31:0] exp;
   } exp_t;

   exp_t exp_q[$];
   event sample_ev;

   // reference: 1024 words, address reduced with plain arithmetic
   logic [31:0] model [1024];

   data_memory dut (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .a     (a),
      .wd    (wd),
      .rd    (rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int ref_index(input logic [31:0] addr);
      return int'((addr / 4) % 1024);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 1024; i++) model[i] = 32'h0;
   endtask

   // push expectation for the current address and let the monitor sample
   task automatic expect_rd(input string name, input logic [31:0] exp);
      exp_t e;
      #1;
      e.name = name;
      e.addr = a;
      e.exp  = exp;
      exp_q.push_back(e);
      -> sample_ev;
      #1;
   endtask

   task automatic check_addr(input string name, input logic [31:0] addr);
      a  = addr;
      we = 1'b0;
      wd = $urandom;
      expect_rd(name, reset ? 32'h0 : model[ref_index(addr)]);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      a  = addr;
      wd = data;
      we = 1'b1;
      @(posedge clk);
      if (!reset) model[ref_index(addr)] = data;
      @(negedge clk);
      we = 1'b0;
   endtask

   // monitor: pop and compare each time a sample is presented
   initial begin
      exp_t e;
      forever begin
         @(sample_ev);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: rd=%h required=<expectation>", rd);
         end else begin
            e = exp_q.pop_front();
            if (rd !== e.exp) begin
               errors++;
               $display("FAIL %s: a=%h rd=%h required=%h", e.name, e.addr, rd, e.exp);
            end
         end
      end
   end

   initial begin
      logic [31:0] ra;
      logic [31:0] rw;
      logic        rwe;

      reset = 1'b1;
      we    = 1'b0;
      a     = 32'h0;
      wd    = 32'h0;
      model_clear();
      repeat (2) @(posedge clk);
      #2;
      check_addr("rd_during_reset", 32'h0000_0050);
      @(negedge clk);
      reset = 1'b0;

      check_addr("reset_clear_0", 32'h0);
      check_addr("reset_clear_4", 32'h4);
      check_addr("reset_clear_50", 32'h50);
      check_addr("reset_clear_ffc", 32'hFFC);

      do_write(32'h0, 32'hA5A5A5A5);
      wd = 32'h12345678;
      @(posedge clk);
      @(negedge clk);
      check_addr("write_read_0", 32'h0);

      do_write(32'h4, 32'hABCDEF78);
      do_write(32'h50, 32'h12121212);
      @(negedge clk);
      wd = 32'hA5A5A5A5;
      @(posedge clk);
      @(negedge clk);
      wd = 32'h12312312;
      @(posedge clk);
      @(negedge clk);
      check_addr("indep_4", 32'h4);
      check_addr("indep_50", 32'h50);
      check_addr("indep_0", 32'h0);

      do_write(32'h1023, 32'hA1B2C3D4);
      @(negedge clk);
      wd = 32'h1A2B3C4D;
      @(posedge clk);
      @(negedge clk);
      check_addr("unaligned_1023", 32'h1023);
      check_addr("alias_20", 32'h20);
      check_addr("alias_21", 32'h21);
      check_addr("alias_22", 32'h22);
      check_addr("alias_high", 32'hFFFF_F020);

      // read-during-write on the same word
      @(negedge clk);
      a  = 32'h4;
      wd = 32'h11111111;
      we = 1'b1;
      expect_rd("rdw_before_edge", model[ref_index(32'h4)]);
      @(posedge clk);
      model[ref_index(32'h4)] = 32'h11111111;
      expect_rd("rdw_after_edge", 32'h11111111);
      @(negedge clk);
      we = 1'b0;

      // asynchronous reset between edges, write held through an edge
      #2;
      a = 32'h50;
      reset = 1'b1;
      model_clear();
      expect_rd("async_reset_immediate", 32'h0);
      we = 1'b1;
      wd = 32'hDEADBEEF;
      @(posedge clk);
      expect_rd("no_write_in_reset", 32'h0);
      @(negedge clk);
      we = 1'b0;
      reset = 1'b0;
      check_addr("post_reset_0", 32'h0);
      check_addr("post_reset_4", 32'h4);
      check_addr("post_reset_50", 32'h50);
      check_addr("post_reset_1023", 32'h1023);
      check_addr("post_reset_50_after_blocked", 32'h50);

      // randomized traffic over a narrow window so reads hit written words
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 63) == 0) begin
            reset = 1'b1;
            model_clear();
            a = $urandom;
            expect_rd("rand_reset", 32'h0);
            @(negedge clk);
            reset = 1'b0;
         end
         ra  = {$urandom_range(0, 3), 18'h0, $urandom_range(0, 63) * 4 + $urandom_range(0, 3)};
         rw  = $urandom;
         rwe = ($urandom_range(0, 1) == 1);
         a  = ra;
         wd = rw;
         we = rwe;
         expect_rd("rand_pre_edge", model[ref_index(ra)]);
         @(posedge clk);
         if (rwe) model[ref_index(ra)] = rw;
         expect_rd("rand_post_edge", model[ref_index(ra)]);
      end

      @(negedge clk);
      we = 1'b0;
      #2;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: pending=%0d required=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
